// File: rtl/vga_rx_decoder.sv
// rtl/vga_rx_decoder.sv - locks to a received VGA/RGB565 stream and recovers pixel coordinates.
// Leading-edge sync tracking, SEARCH/ALIGN/LOCKED lock FSM, two-clock pin-to-output latency.
module vga_rx_decoder #(
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int H_ACTIVE = 1280,
  parameter int H_TOTAL  = 1650,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int V_ACTIVE = 720,
  parameter int V_TOTAL  = 750,
  parameter int SYNC_POL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] rgb,
  output logic        locked,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        sof,
  output logic [7:0]  err_cnt
);
  localparam logic        POL     = (SYNC_POL != 0);
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] V_LINES = 12'(V_TOTAL);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [15:0] rgb1_q, rgb1_d;
  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [11:0] lines_q, lines_d;
  logic        seen_q, seen_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        pix_valid_q, pix_valid_d;
  logic [10:0] pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        sof_q, sof_d;
  logic        hs_lead, vs_lead, line_err, frame_err, in_h, in_v;

  always_comb begin
    hs1_d  = hsync;
    vs1_d  = vsync;
    rgb1_d = rgb;
    hs2_d  = hs1_q;
    vs2_d  = vs1_q;

    hs_lead = (hs1_q == POL) && (hs2_q != POL);
    vs_lead = (vs1_q == POL) && (vs2_q != POL);

    // h_d/v_d describe the sample now in S1; h_q/v_q belong to the sample before it.
    h_d = hs_lead ? 11'd0 : ((h_q == 11'h7FF) ? h_q : h_q + 11'd1);
    v_d = v_q;
    if (vs_lead) begin
      v_d = 10'd0;
    end else if (hs_lead && (v_q != 10'h3FF)) begin
      v_d = v_q + 10'd1;
    end

    line_err  = hs_lead && seen_q && (h_q != H_LAST);
    frame_err = vs_lead && (lines_q != V_LINES);

    // An hsync edge coinciding with the vsync edge belongs to the new frame.
    lines_d = lines_q;
    if (vs_lead) begin
      lines_d = {11'd0, hs_lead};
    end else if (hs_lead && (lines_q != 12'hFFF)) begin
      lines_d = lines_q + 12'd1;
    end
    seen_d = seen_q | hs_lead;

    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      SEARCH: begin
        if (vs_lead) begin
          state_d = ALIGN;
          seen_d  = hs_lead;
        end
      end
      ALIGN: begin
        if (line_err) begin
          state_d = SEARCH;
        end else if (vs_lead && !frame_err) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (line_err || frame_err) begin
          state_d = SEARCH;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = SEARCH;
    endcase

    // Qualify with the next state so pix_valid never outlives locked.
    in_h        = (h_d >= H_START) && (h_d < H_END);
    in_v        = (v_d >= V_START) && (v_d < V_END);
    pix_valid_d = (state_d == LOCKED) && in_h && in_v;
    pix_x_d     = pix_valid_d ? (h_d - H_START) : 11'd0;
    pix_y_d     = pix_valid_d ? (v_d - V_START) : 10'd0;
    pix_data_d  = pix_valid_d ? rgb1_q : 16'd0;
    sof_d       = pix_valid_d && (pix_x_d == 11'd0) && (pix_y_d == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      rgb1_q      <= 16'd0;
      h_q         <= 11'd0;
      v_q         <= 10'd0;
      lines_q     <= 12'd0;
      seen_q      <= 1'b0;
      err_cnt_q   <= 8'd0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= 11'd0;
      pix_y_q     <= 10'd0;
      pix_data_q  <= 16'd0;
      sof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
      rgb1_q      <= rgb1_d;
      h_q         <= h_d;
      v_q         <= v_d;
      lines_q     <= lines_d;
      seen_q      <= seen_d;
      err_cnt_q   <= err_cnt_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_data_q  <= pix_data_d;
      sof_q       <= sof_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_data  = pix_data_q;
  assign sof       = sof_q;
  assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_vga_rx_decoder.sv
// tb/tb_vga_rx_decoder.sv - randomized stream check of vga_rx_decoder against a pin-level timing model.
// Both sync polarities are driven from one generator and must produce identical outputs.
`timescale 1ns/1ps
module tb_vga_rx_decoder;
  localparam int HS = 1, HB = 2, HA = 6, HT = 12;
  localparam int VS = 1, VB = 1, VA = 4, VT = 7;
  localparam int K_SNAP = 1, K_NOM = 2, K_ERR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs_pin = 1'b0, vs_pin = 1'b0;
  logic [15:0] rgb_pin = 16'd0;
  logic hs_n, vs_n;

  logic        locked_p, pv_p, sof_p, locked_n, pv_n, sof_n;
  logic [10:0] px_p, px_n;
  logic [9:0]  py_p, py_n;
  logic [15:0] pd_p, pd_n;
  logic [7:0]  err_p, err_n;

  int checks = 0;
  int errors = 0;

  int req_id = 0, req_kind = 0, req_val = 0, req_lock = 0;

  assign hs_n = ~hs_pin;
  assign vs_n = ~vs_pin;

  always #5 clk = ~clk;

  vga_rx_decoder #(.H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_TOTAL(HT), .V_SYNC(VS), .V_BP(VB),
                   .V_ACTIVE(VA), .V_TOTAL(VT), .SYNC_POL(1)) dut_p (
    .clk(clk), .rst(rst), .hsync(hs_pin), .vsync(vs_pin), .rgb(rgb_pin),
    .locked(locked_p), .pix_valid(pv_p), .pix_x(px_p), .pix_y(py_p), .pix_data(pd_p),
    .sof(sof_p), .err_cnt(err_p));

  vga_rx_decoder #(.H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_TOTAL(HT), .V_SYNC(VS), .V_BP(VB),
                   .V_ACTIVE(VA), .V_TOTAL(VT), .SYNC_POL(0)) dut_n (
    .clk(clk), .rst(rst), .hsync(hs_n), .vsync(vs_n), .rgb(rgb_pin),
    .locked(locked_n), .pix_valid(pv_n), .pix_x(px_n), .pix_y(py_n), .pix_data(pd_n),
    .sof(sof_n), .err_cnt(err_n));

  // ---------------- reference model and compare process ----------------
  int  m_idx, m_last_hs, m_v, m_lines, m_state, m_err;
  bit  m_have, m_phs, m_pvs;
  logic [47:0] slot_a, slot_b;
  bit  va = 0, vb = 0;
  int  cyc = 0, last_vs_cyc = 0, vs_since = 0, pix_cnt = 0, sof_cnt = 0, base_pix = 0, base_sof = 0;
  int  req_seen = 0;
  bit  prev_vs_pin = 0, prev_locked = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_last_hs = 0; m_v = 0; m_lines = 0; m_state = 0; m_err = 0;
    m_have = 0; m_phs = 0; m_pvs = 0;
  endtask

  // State 0 = searching, 1 = aligning, 2 = locked; h is the distance to the last hsync edge.
  task automatic model_step(input bit hs, input bit vs, input logic [15:0] d, output logic [47:0] e);
    bit hs_e, vs_e, line_bad, frame_bad, valid, lk;
    int h, xo, yo;
    m_idx++;
    hs_e = hs && !m_phs;
    vs_e = vs && !m_pvs;
    m_phs = hs;
    m_pvs = vs;
    line_bad  = hs_e && m_have && ((m_idx - m_last_hs) != HT);
    frame_bad = vs_e && (m_lines != VT);
    if (hs_e) m_last_hs = m_idx;
    h = m_idx - m_last_hs;
    if (h > 2047) h = 2047;
    if (vs_e) m_v = 0;
    else if (hs_e && m_v < 1023) m_v++;
    if (vs_e) m_lines = hs_e ? 1 : 0;
    else if (hs_e) m_lines++;
    if (hs_e) m_have = 1;
    if (m_state == 0) begin
      if (vs_e) begin m_state = 1; m_have = hs_e; end
    end else if (m_state == 1) begin
      if (line_bad) m_state = 0;
      else if (vs_e && !frame_bad) m_state = 2;
    end else if (line_bad || frame_bad) begin
      m_state = 0;
      if (m_err < 255) m_err++;
    end
    lk = (m_state == 2);
    valid = lk && h >= HS + HB && h < HS + HB + HA && m_v >= VS + VB && m_v < VS + VB + VA;
    xo = valid ? h - (HS + HB) : 0;
    yo = valid ? m_v - (VS + VB) : 0;
    e = {lk, valid, 11'(xo), 10'(yo), valid ? d : 16'd0, valid && xo == 0 && yo == 0, 8'(m_err)};
  endtask

  always @(negedge clk) begin
    cyc++;
    if (va) begin
      chk("outputs_pol1", {locked_p, pv_p, px_p, py_p, pd_p, sof_p, err_p}, slot_a);
      chk("outputs_pol0", {locked_n, pv_n, px_n, py_n, pd_n, sof_n, err_n}, slot_a);
    end
    if (pv_p) begin
      pix_cnt++;
      chk("pix_pattern", pd_p, {py_p[4:0], px_p[5:0], px_p[4:0]});
    end
    if (sof_p) sof_cnt++;
    if (locked_p && !prev_locked) begin
      chk("lock_gap_clocks", cyc - last_vs_cyc, 2);
      chk("lock_vsync_edges", vs_since, 2);
    end
    if (!locked_p && prev_locked) vs_since = 0;
    prev_locked = locked_p;
    if (rst) vs_since = 0;
    else if (vs_pin && !prev_vs_pin) begin
      vs_since++;
      last_vs_cyc = cyc;
    end
    prev_vs_pin = vs_pin;

    if (req_id != req_seen) begin
      req_seen = req_id;
      if (req_kind == K_SNAP) begin
        base_pix = pix_cnt;
        base_sof = sof_cnt;
      end else begin
        if (req_kind == K_NOM) begin
          chk("frame_pixels", pix_cnt - base_pix, 3 * HA * VA);
          chk("frame_sofs", sof_cnt - base_sof, 3);
        end
        chk("err_cnt_lit", err_p, req_val);
        chk("err_cnt_lit_pol0", err_n, req_val);
        chk("locked_lit", locked_p, req_lock);
      end
    end

    slot_a = slot_b;
    va = vb;
    if (rst) begin
      model_reset();
      slot_a = '0; va = 1;
      slot_b = '0; vb = 1;
    end else begin
      model_step(hs_pin, vs_pin, rgb_pin, slot_b);
      vb = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit r, input bit h, input bit v, input logic [15:0] d);
    @(posedge clk);
    #1;
    rst = r; hs_pin = h; vs_pin = v; rgb_pin = d;
  endtask

  task automatic request(input int kind, input int val, input int lk);
    req_kind = kind; req_val = val; req_lock = lk;
    req_id++;
  endtask

  task automatic emit_frame(input int nlines, input int l0, input int c0, input int short_line,
                            input int rst_line);
    int len, cs;
    bit act;
    logic [5:0] xx;
    logic [4:0] yy;
    logic [15:0] d;
    for (int l = l0; l < nlines; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      cs = (l == l0) ? c0 : 0;
      for (int c = cs; c < len; c++) begin
        act = (l >= VS + VB) && (l < VS + VB + VA) && (c >= HS + HB) && (c < HS + HB + HA);
        xx = 6'(c - (HS + HB));
        yy = 5'(l - (VS + VB));
        d = act ? {yy, xx, xx[4:0]} : 16'($urandom);
        drive((l == rst_line) && (c == HS + HB + 1), c < HS, l < VS, d);
      end
    end
  endtask

  task automatic good_frames(input int n);
    for (int i = 0; i < n; i++) emit_frame(VT, 0, 0, -1, -1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 16'd0);
    request(K_ERR, 0, 0);
    emit_frame(VT, 3, 6, -1, -1);
    emit_frame(VT, 0, 0, -1, -1);
    request(K_SNAP, 0, 0);
    good_frames(3);
    request(K_NOM, 0, 1);

    emit_frame(VT, 0, 0, 3, -1);
    good_frames(3);
    request(K_ERR, 1, 1);

    emit_frame(VT, 0, 0, -1, 3);
    request(K_ERR, 0, 0);
    good_frames(3);
    request(K_ERR, 0, 1);

    emit_frame(VT - 1, 0, 0, VT - 2, -1);
    good_frames(3);
    request(K_ERR, 1, 1);

    emit_frame(VT - 1, 0, 0, -1, -1);
    good_frames(3);
    request(K_ERR, 2, 1);

    for (int i = 0; i < 300; i++) begin
      emit_frame(2, 0, 0, -1, -1);
      emit_frame(2, 0, 0, -1, -1);
      emit_frame(VT, 0, 0, -1, -1);
    end
    good_frames(2);
    request(K_ERR, 255, 1);
    drive(0, 0, 0, 16'd0);
    drive(0, 0, 0, 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_rx_decoder.md
Name: vga_rx_decoder

Overview:
- Receive-side counterpart of the game's VGA/RGB565 output path. Consumes hsync, vsync and rgb exactly as driven at the board pins.
- Locks to the timing and recovers pixel coordinates, a pixel-valid strobe and start-of-frame.
- Counts timing violations.
- Used for loopback self-check of the display chain and as a scoreboard front-end in system simulation.
- Runs in the pixel clock domain (74.25 MHz, 1280x720).

Parameters:
- H_SYNC, 40, hsync pulse width in clocks
- H_BP, 220, horizontal back porch in clocks
- H_ACTIVE, 1280, active pixels per line
- H_TOTAL, 1650, clocks per line
- V_SYNC, 5, vsync pulse width in lines
- V_BP, 20, vertical back porch in lines
- V_ACTIVE, 720, active lines per frame
- V_TOTAL, 750, lines per frame
- SYNC_POL, 1, asserted level of hsync/vsync (1 = active-high)

Ports:
- clk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous reset, active-high
- hsync  in  1  received horizontal sync
- vsync  in  1  received vertical sync
- rgb  in  16  received pixel, RGB565 {R[4:0],G[5:0],B[4:0]}
- locked  out  1  timing verified, outputs trustworthy
- pix_valid  out  1  pix_x/pix_y/pix_data describe an active pixel
- pix_x  out  11  active column 0..H_ACTIVE-1
- pix_y  out  10  active row 0..V_ACTIVE-1
- pix_data  out  16  pixel aligned with pix_x/pix_y
- sof  out  1  one-cycle pulse with pixel (0,0)
- err_cnt  out  8  saturating count of lock losses

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): all outputs 0, state SEARCH, all counters and input registers 0. Reset mid-frame discards the partial frame; lock restarts from SEARCH.
- Input stage: hsync, vsync and rgb are registered once (stage S1). The previous S1 sync values are held in S2. A leading edge is S1 asserted (==SYNC_POL) while S2 is not.
- Horizontal index h: 0 on the S1 sample carrying the hsync leading edge, otherwise previous h+1. Saturates at 2047.
- Vertical index v: 0 on a vsync leading edge. This takes priority when it coincides with an hsync edge. Otherwise v+1 on each hsync leading edge, saturating at 1023.
- Line check: at each hsync leading edge after the first since SEARCH, the previous h must equal H_TOTAL-1. Otherwise it is a line error.
- Frame check: at each vsync leading edge, the number of hsync leading edges since the previous vsync edge must equal V_TOTAL. Otherwise it is a frame error.
- State machine SEARCH / ALIGN / LOCKED:
  - SEARCH: on a vsync leading edge, go to ALIGN and clear the line-check history. Line and frame errors are ignored in SEARCH.
  - ALIGN: a line error returns to SEARCH, with no err_cnt change. The next vsync leading edge with a passing frame check and no line error since entering ALIGN goes to LOCKED. A failing frame check stays in ALIGN and restarts the count.
  - LOCKED: a line or frame error goes to SEARCH and increments err_cnt (saturates at 255). locked drops on the same cycle the state leaves LOCKED.
- locked = (state == LOCKED), registered.
- Output stage (S3, latency 2 clocks from pin to output):
  - pix_valid = LOCKED and H_SYNC+H_BP <= h < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= v < V_SYNC+V_BP+V_ACTIVE.
  - pix_x = h-(H_SYNC+H_BP) and pix_y = v-(V_SYNC+V_BP), truncated to port width.
  - pix_data = S1 rgb.
  - When pix_valid=0, pix_x, pix_y and pix_data hold 0.
  - sof = pix_valid and pix_x==0 and pix_y==0.
- A simultaneous line error and frame error counts once.
- Sync levels are never trusted mid-line. Only leading edges are used; trailing-edge position is not checked.

Test Plan:
- Nominal 720p stream from a reference timing generator, reset released at an arbitrary line -> locked rises 2 clocks after the second vsync leading edge following reset; each subsequent frame gives exactly 921600 pix_valid cycles, pix_x 0..1279 and pix_y 0..719 in raster order, one sof per frame, err_cnt=0.
- Pixel pattern rgb = {pix_y[4:0], pix_x[5:0], pix_x[4:0]} applied at the pins -> pix_data matches its own coordinates on every valid cycle, proving the 2-clock alignment.
- While locked, one line shortened to 1649 clocks -> locked=0 right after that hsync edge, err_cnt=1, pix_valid=0 until relock; locked returns after 2 further vsync leading edges.
- While locked, one frame with 749 lines -> locked drops at the vsync edge, err_cnt=1; a line error on the same edge still yields err_cnt=1.
- rst=1 for 1 clock mid-frame while locked -> next clock all outputs 0, err_cnt=0; relock proceeds as in scenario 1.
- SYNC_POL=0 with inverted syncs, plus 300 forced lock losses -> same lock behaviour as scenario 1; err_cnt saturates at 255.
